// File: rtl/lpif_arb_pkg.sv
// lpif_arb_pkg: shared types, widths and helpers for the LPIF downstream arbiter
package lpif_arb_pkg;
  localparam int PROTID_W = 2;
  localparam int MAX_REQ = 4;
  typedef enum logic {IDLE, LOCK} arb_state_e;
  function automatic logic [3:0] eff_flit_len(input logic [3:0] cfg);
    return (cfg == 4'd0) ? 4'd1 : cfg;
  endfunction
endpackage

// File: rtl/lpif_rr_arbiter.sv
// lpif_rr_arbiter: combinational round-robin picker starting after last_grant
module lpif_rr_arbiter
  import lpif_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [PROTID_W-1:0] last_grant,
  output logic [NUM_REQ-1:0]  gnt_oh,
  output logic [PROTID_W-1:0] gnt_idx
);
  int   idx;
  logic found;
  always_comb begin
    idx = 0;
    found = 1'b0;
    gnt_idx = last_grant;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        gnt_idx = idx[PROTID_W-1:0];
      end
    end
    gnt_oh = found ? (NUM_REQ'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/lpif_dstrm_arbiter.sv
// lpif_dstrm_arbiter: round-robin flit arbiter sharing the LPIF dstrm_* channel
module lpif_dstrm_arbiter
  import lpif_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 512,
  parameter int CRC_W   = 16
) (
  input  logic                     clk_wr,
  input  logic                     rst_wr,
  input  logic                     cfg_enable,
  input  logic [3:0]               cfg_flit_beats,
  input  logic [3:0]               cfg_state,
  input  logic                     link_up,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*CRC_W-1:0] req_crc,
  input  logic [NUM_REQ-1:0]       req_crc_valid,
  output logic [3:0]               dstrm_state,
  output logic [PROTID_W-1:0]      dstrm_protid,
  output logic [DATA_W-1:0]        dstrm_data,
  output logic                     dstrm_dvalid,
  output logic [CRC_W-1:0]         dstrm_crc,
  output logic                     dstrm_crc_valid,
  output logic                     dstrm_valid,
  output logic [PROTID_W-1:0]      cur_grant,
  output logic                     busy,
  output logic                     abort_pulse
);
  arb_state_e                       state_q, state_d;
  logic [PROTID_W-1:0]              gnt_q, gnt_d, last_q, last_d, cur_q, cur_d, sel;
  logic [3:0]                       cnt_q, cnt_d, len_q, len_d, len_eff;
  logic                             abort_q, abort_d, acc;
  logic [NUM_REQ-1:0]               ready, win_oh;
  logic [PROTID_W-1:0]              win_idx;
  logic [MAX_REQ-1:0]               vld_p, cv_p;
  logic [MAX_REQ-1:0][DATA_W-1:0]   data_a;
  logic [MAX_REQ-1:0][CRC_W-1:0]    crc_a;
  logic [3:0]                       st_q, st_d;
  logic [PROTID_W-1:0]              pid_q, pid_d;
  logic [DATA_W-1:0]                data_q, data_d;
  logic [CRC_W-1:0]                 crc_q, crc_d;
  logic                             dv_q, dv_d, cv_q, cv_d, v_q, v_d;

  // Pad client vectors to MAX_REQ so a 2-bit grant index is always in range
  for (genvar i = 0; i < MAX_REQ; i++) begin : g_pad
    if (i < NUM_REQ) begin : g_use
      assign vld_p[i]  = req_valid[i];
      assign cv_p[i]   = req_crc_valid[i];
      assign data_a[i] = req_data[i*DATA_W +: DATA_W];
      assign crc_a[i]  = req_crc[i*CRC_W +: CRC_W];
    end else begin : g_nil
      assign vld_p[i]  = 1'b0;
      assign cv_p[i]   = 1'b0;
      assign data_a[i] = '0;
      assign crc_a[i]  = '0;
    end
  end

  lpif_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_q),
    .gnt_oh     (win_oh),
    .gnt_idx    (win_idx)
  );

  assign len_eff = eff_flit_len(cfg_flit_beats);

  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    last_d = last_q;
    cur_d = cur_q;
    cnt_d = cnt_q;
    len_d = len_q;
    abort_d = 1'b0;
    ready = '0;
    acc = 1'b0;
    sel = (state_q == IDLE) ? win_idx : gnt_q;
    if (state_q == IDLE) begin
      if (cfg_enable && link_up && |req_valid) begin
        ready = win_oh;
        acc = 1'b1;
        cur_d = win_idx;
        if (len_eff == 4'd1) begin
          last_d = win_idx;
        end else begin
          state_d = LOCK;
          gnt_d = win_idx;
          cnt_d = 4'd1;
          len_d = len_eff;
        end
      end
    end else if (!link_up) begin
      state_d = IDLE;
      abort_d = 1'b1;
      last_d = gnt_q;
    end else begin
      ready = NUM_REQ'(1) << gnt_q;
      acc = vld_p[gnt_q];
      if (acc) begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == len_q - 4'd1) begin
          state_d = IDLE;
          last_d = gnt_q;
        end
      end
    end
    dv_d = acc;
    data_d = acc ? data_a[sel] : data_q;
    crc_d = acc ? crc_a[sel] : crc_q;
    pid_d = acc ? sel : pid_q;
    cv_d = acc & cv_p[sel];
    v_d = link_up;
    st_d = cfg_state;
  end

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      state_q <= IDLE;
      gnt_q <= '0;
      last_q <= PROTID_W'(NUM_REQ - 1);
      cur_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      abort_q <= 1'b0;
      dv_q <= 1'b0;
      data_q <= '0;
      crc_q <= '0;
      pid_q <= '0;
      cv_q <= 1'b0;
      v_q <= 1'b0;
      st_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
      cur_q <= cur_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      abort_q <= abort_d;
      dv_q <= dv_d;
      data_q <= data_d;
      crc_q <= crc_d;
      pid_q <= pid_d;
      cv_q <= cv_d;
      v_q <= v_d;
      st_q <= st_d;
    end
  end

  assign req_ready = rst_wr ? '0 : ready;
  assign dstrm_state = st_q;
  assign dstrm_protid = pid_q;
  assign dstrm_data = data_q;
  assign dstrm_dvalid = dv_q;
  assign dstrm_crc = crc_q;
  assign dstrm_crc_valid = cv_q;
  assign dstrm_valid = v_q;
  assign cur_grant = cur_q;
  assign busy = (state_q == LOCK);
  assign abort_pulse = abort_q;
endmodule

// File: tb/tb_lpif_dstrm_arbiter.sv
// tb_lpif_dstrm_arbiter: directed self-checking bench for lpif_dstrm_arbiter
module tb_lpif_dstrm_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_enable = 1'b1;
  logic [3:0]  cfg_flit_beats = 4'd4;
  logic [3:0]  cfg_state = 4'h5;
  logic        link_up = 1'b1;
  logic [3:0]  req_valid = 4'b1111;
  logic [3:0]  req_ready;
  logic [127:0] req_data = '0;
  logic [63:0] req_crc = '0;
  logic [3:0]  req_crc_valid = 4'b0101;
  logic [3:0]  dstrm_state;
  logic [1:0]  dstrm_protid, cur_grant;
  logic [31:0] dstrm_data;
  logic        dstrm_dvalid, dstrm_crc_valid, dstrm_valid, busy, abort_pulse;
  logic [15:0] dstrm_crc;
  int          n_tot = 0, n_pass = 0, n_fail = 0;
  logic [15:0] seq = 16'h0100;
  logic [31:0] ld = '0;
  logic [15:0] lc = '0;
  logic [1:0]  lp = '0;

  always #5 clk = ~clk;

  lpif_dstrm_arbiter #(.NUM_REQ(4), .DATA_W(32), .CRC_W(16)) dut (
    .clk_wr(clk), .rst_wr(rst), .cfg_enable(cfg_enable), .cfg_flit_beats(cfg_flit_beats),
    .cfg_state(cfg_state), .link_up(link_up), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_crc(req_crc), .req_crc_valid(req_crc_valid),
    .dstrm_state(dstrm_state), .dstrm_protid(dstrm_protid), .dstrm_data(dstrm_data),
    .dstrm_dvalid(dstrm_dvalid), .dstrm_crc(dstrm_crc), .dstrm_crc_valid(dstrm_crc_valid),
    .dstrm_valid(dstrm_valid), .cur_grant(cur_grant), .busy(busy), .abort_pulse(abort_pulse)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive valids and fresh data, check ready, then the registered result
  task automatic beat(input logic [3:0] v, input logic [3:0] er, input logic ed,
                      input logic [1:0] ep, input logic eb);
    logic [31:0] xd;
    logic [15:0] xc;
    req_valid = v;
    for (int i = 0; i < 4; i++) begin
      req_data[i*32 +: 32] = {8'hD0 + 8'(i), 8'h00, seq};
      req_crc[i*16 +: 16] = {4'hC, 2'b00, 2'(i), seq[7:0]};
    end
    seq++;
    #1 chk("req_ready", req_ready, er);
    xd = req_data[ep*32 +: 32];
    xc = req_crc[ep*16 +: 16];
    @(posedge clk);
    #1;
    if (ed) begin
      ld = xd;
      lc = xc;
      lp = ep;
      chk("cur_grant", cur_grant, ep);
    end
    chk("dvalid", dstrm_dvalid, ed);
    chk("data", dstrm_data, ld);
    chk("crc", dstrm_crc, lc);
    chk("protid", dstrm_protid, lp);
    chk("crc_valid", dstrm_crc_valid, ed & req_crc_valid[ep]);
    chk("busy", busy, eb);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_dvalid", dstrm_dvalid, 0);
    chk("rst_valid", dstrm_valid, 0);
    chk("rst_state", dstrm_state, 0);
    chk("rst_data", dstrm_data, 0);
    chk("rst_protid", dstrm_protid, 0);
    chk("rst_crc_valid", dstrm_crc_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cur_grant", cur_grant, 0);
    chk("rst_abort", abort_pulse, 0);
    rst = 1'b0;
    // single client, 4-beat flits, 8 beats
    beat(4'b0001, 4'b0001, 1, 0, 1);
    chk("state_out", dstrm_state, 4'h5);
    chk("valid_out", dstrm_valid, 1);
    beat(4'b0001, 4'b0001, 1, 0, 1);
    beat(4'b0001, 4'b0001, 1, 0, 1);
    beat(4'b0001, 4'b0001, 1, 0, 0);
    beat(4'b0001, 4'b0001, 1, 0, 1);
    beat(4'b0001, 4'b0001, 1, 0, 1);
    beat(4'b0001, 4'b0001, 1, 0, 1);
    beat(4'b0001, 4'b0001, 1, 0, 0);
    beat(4'b0000, 4'b0000, 0, 0, 0);
    // all clients, 2-beat flits, rotation after last grant 0
    cfg_flit_beats = 4'd2;
    beat(4'b1111, 4'b0010, 1, 1, 1);
    beat(4'b1111, 4'b0010, 1, 1, 0);
    beat(4'b1111, 4'b0100, 1, 2, 1);
    beat(4'b1111, 4'b0100, 1, 2, 0);
    beat(4'b1111, 4'b1000, 1, 3, 1);
    beat(4'b1111, 4'b1000, 1, 3, 0);
    beat(4'b1111, 4'b0001, 1, 0, 1);
    beat(4'b1111, 4'b0001, 1, 0, 0);
    beat(4'b1111, 4'b0010, 1, 1, 1);
    beat(4'b1111, 4'b0010, 1, 1, 0);
    beat(4'b0000, 4'b0000, 0, 0, 0);
    // client 1 bubbles for 3 cycles; mid-flit length change ignored
    cfg_flit_beats = 4'd4;
    beat(4'b0010, 4'b0010, 1, 1, 1);
    beat(4'b0010, 4'b0010, 1, 1, 1);
    cfg_flit_beats = 4'd1;
    beat(4'b1101, 4'b0010, 0, 1, 1);
    beat(4'b1101, 4'b0010, 0, 1, 1);
    beat(4'b1101, 4'b0010, 0, 1, 1);
    beat(4'b1111, 4'b0010, 1, 1, 1);
    beat(4'b1111, 4'b0010, 1, 1, 0);
    beat(4'b0000, 4'b0000, 0, 0, 0);
    // zero length means single-beat flits, alternating 2,0 from last grant 1
    cfg_flit_beats = 4'd0;
    beat(4'b0101, 4'b0100, 1, 2, 0);
    beat(4'b0101, 4'b0001, 1, 0, 0);
    beat(4'b0101, 4'b0100, 1, 2, 0);
    beat(4'b0101, 4'b0001, 1, 0, 0);
    // link drop after 2 of 4 beats
    cfg_flit_beats = 4'd4;
    beat(4'b0101, 4'b0100, 1, 2, 1);
    beat(4'b0101, 4'b0100, 1, 2, 1);
    link_up = 1'b0;
    beat(4'b0101, 4'b0000, 0, 2, 0);
    chk("abort_hi", abort_pulse, 1);
    chk("valid_lo", dstrm_valid, 0);
    link_up = 1'b1;
    beat(4'b0101, 4'b0001, 1, 0, 1);
    chk("abort_lo", abort_pulse, 0);
    // reset in the middle of client 0's flit
    rst = 1'b1;
    #1 chk("rstm_ready", req_ready, 0);
    @(posedge clk);
    #1;
    chk("rstm_dvalid", dstrm_dvalid, 0);
    chk("rstm_data", dstrm_data, 0);
    chk("rstm_crc", dstrm_crc, 0);
    chk("rstm_valid", dstrm_valid, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_abort", abort_pulse, 0);
    chk("rstm_cur_grant", cur_grant, 0);
    rst = 1'b0;
    ld = '0;
    lc = '0;
    lp = '0;
    beat(4'b0101, 4'b0001, 1, 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
